// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
// The PC_BTB_EN macro adds a direct-mapped branch target buffer to pc_fetch_unit.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BTB,
        SEL_REDIR,
        SEL_TRAP
    } pc_sel_e;

    localparam int ALIGN_BITS = 2;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int btb_tag_w(input int width, input int entries);
        return width - $clog2(entries) - ALIGN_BITS;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the current PC,
// write/invalidate on the training port at the clock edge (lookup sees old contents).
module pc_btb
    import pc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic             hit,
    output logic [WIDTH-1:0] target,
    input  logic             upd_valid,
    input  logic [WIDTH-1:0] upd_pc,
    input  logic [WIDTH-1:0] upd_target,
    input  logic             upd_taken
);

    localparam int IDX_W = btb_idx_w(ENTRIES);
    localparam int TAG_W = btb_tag_w(WIDTH, ENTRIES);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [WIDTH-1:0]   targets [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             unused_low_bits;

    assign lk_idx = pc[IDX_W+ALIGN_BITS-1:ALIGN_BITS];
    assign lk_tag = pc[WIDTH-1:IDX_W+ALIGN_BITS];
    assign up_idx = upd_pc[IDX_W+ALIGN_BITS-1:ALIGN_BITS];
    assign up_tag = upd_pc[WIDTH-1:IDX_W+ALIGN_BITS];
    assign unused_low_bits = &{1'b0, pc[ALIGN_BITS-1:0], upd_pc[ALIGN_BITS-1:0]};

    assign hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign target = targets[lk_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid[up_idx] <= 1'b1;
            end else if (tags[up_idx] == up_tag) begin
                valid[up_idx] <= 1'b0;
            end
        end
    end

    // Tag/target arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with stall, imem handshake, trap/redirect priority and halt.
// Define PC_BTB_EN to compile in the pc_btb predictor; otherwise pred_taken_o is tied low.
//   state | meaning
//   BOOT  | one cycle after reset, pc = RESET_VECTOR, no request
//   RUN   | fetching, imem_req_o = 1
//   HALT  | stopped, waits for a trap or aligned redirect
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               BTB_ENTRIES  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    input  logic             trap_valid_i,
    input  logic [WIDTH-1:0] trap_vector_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_ready_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus_step_o,
    output logic             misaligned_o,
    output logic             pred_taken_o,
    input  logic             btb_upd_valid_i,
    input  logic [WIDTH-1:0] btb_upd_pc_i,
    input  logic [WIDTH-1:0] btb_upd_target_i,
    input  logic             btb_upd_taken_i
);

    pc_state_e        state;
    pc_sel_e          sel;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_pc;
    logic             accept;
    logic             redir_aligned;
    logic             redir_taken;
    logic             btb_hit;
    logic [WIDTH-1:0] btb_target;

`ifdef PC_BTB_EN
    pc_btb #(
        .WIDTH   (WIDTH),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .hit        (btb_hit),
        .target     (btb_target),
        .upd_valid  (btb_upd_valid_i),
        .upd_pc     (btb_upd_pc_i),
        .upd_target (btb_upd_target_i),
        .upd_taken  (btb_upd_taken_i)
    );
`else
    logic unused_btb;
    assign btb_hit    = 1'b0;
    assign btb_target = '0;
    assign unused_btb = &{1'b0, btb_upd_valid_i, btb_upd_pc_i, btb_upd_target_i,
                          btb_upd_taken_i, BTB_ENTRIES[0]};
`endif

    assign imem_req_o     = (state == RUN);
    assign accept         = imem_req_o & imem_ready_i & ~stall_i;
    assign redir_aligned  = (redirect_target_i[ALIGN_BITS-1:0] == '0);
    assign redir_taken    = trap_valid_i | (redirect_valid_i & redir_aligned);
    assign pc_plus_step_o = pc + WIDTH'(STEP);
    assign pc_o           = pc;
    assign imem_addr_o    = pc;
    assign pred_taken_o   = (sel == SEL_BTB);

    always_comb begin
        sel = SEL_HOLD;
        if (trap_valid_i) begin
            sel = SEL_TRAP;
        end else if (redirect_valid_i) begin
            sel = redir_aligned ? SEL_REDIR : SEL_HOLD;
        end else if (accept) begin
            sel = btb_hit ? SEL_BTB : SEL_SEQ;
        end
    end

    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_TRAP:  next_pc = {trap_vector_i[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
            SEL_REDIR: next_pc = redirect_target_i;
            SEL_BTB:   next_pc = btb_target;
            SEL_SEQ:   next_pc = pc_plus_step_o;
            default:   next_pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            misaligned_o <= 1'b0;
        end else begin
            pc           <= next_pc;
            misaligned_o <= redirect_valid_i & ~trap_valid_i & ~redir_aligned;
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    // Halt waits only on an outstanding not-ready request; any redirect overrides it.
                    if (halt_i && !redirect_valid_i && !trap_valid_i && imem_ready_i) begin
                        state <= HALT;
                    end
                end
                HALT: begin
                    if (redir_taken) begin
                        state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected PCs are queued at stimulus time and
// popped one cycle later; BTB expectations follow whether PC_BTB_EN is defined.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, halt_i;
    logic        redirect_valid_i, trap_valid_i;
    logic [31:0] redirect_target_i, trap_vector_i;
    logic        imem_req_o, imem_ready_i;
    logic [31:0] imem_addr_o, pc_o, pc_plus_step_o;
    logic        misaligned_o, pred_taken_o;
    logic        btb_upd_valid_i, btb_upd_taken_i;
    logic [31:0] btb_upd_pc_i, btb_upd_target_i;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

`ifdef PC_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .BTB_ENTRIES  (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall_i),
        .halt_i            (halt_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_target_i (redirect_target_i),
        .trap_valid_i      (trap_valid_i),
        .trap_vector_i     (trap_vector_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .pc_o              (pc_o),
        .pc_plus_step_o    (pc_plus_step_o),
        .misaligned_o      (misaligned_o),
        .pred_taken_o      (pred_taken_o),
        .btb_upd_valid_i   (btb_upd_valid_i),
        .btb_upd_pc_i      (btb_upd_pc_i),
        .btb_upd_target_i  (btb_upd_target_i),
        .btb_upd_taken_i   (btb_upd_taken_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; halt_i = 0; redirect_valid_i = 0; trap_valid_i = 0;
        redirect_target_i = 0; trap_vector_i = 0; imem_ready_i = 1;
        btb_upd_valid_i = 0; btb_upd_taken_i = 0; btb_upd_pc_i = 0; btb_upd_target_i = 0;
    endtask

    task automatic jump(input logic [31:0] t);
        redirect_valid_i = 1; redirect_target_i = t;
        exp_q.push_back(t);
        tick();
        redirect_valid_i = 0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL jump pc=%h exp=%h", pc_o, e); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        n_cmp++;
        if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || misaligned_o !== 1'b0 || pred_taken_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vals pc=%h req=%b mis=%b pred=%b exp 0/0/0/0",
                     pc_o, imem_req_o, misaligned_o, pred_taken_o);
        end
        rst = 0;
        n_cmp++;
        if (imem_req_o !== 1'b0) begin n_err++; $display("FAIL boot_req req=%b exp 0", imem_req_o); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'(i * 4));
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc_o !== e || imem_req_o !== 1'b1) begin
                n_err++; $display("FAIL seq pc=%h req=%b exp %h/1", pc_o, imem_req_o, e);
            end
        end
    endtask

    task automatic test_stall();
        jump(32'h10);
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h10);
            tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc_o !== e || imem_req_o !== 1'b1 || imem_addr_o !== e) begin
                n_err++; $display("FAIL stall_hold pc=%h req=%b exp %h/1", pc_o, imem_req_o, e);
            end
        end
        stall_i = 0;
        exp_q.push_back(32'h14);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL stall_release pc=%h exp=%h", pc_o, e); end
    endtask

    task automatic test_priority();
        jump(32'h20);
        stall_i = 1; imem_ready_i = 0;
        redirect_valid_i = 1; redirect_target_i = 32'h100;
        trap_valid_i = 1; trap_vector_i = 32'h83;
        exp_q.push_back(32'h80);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL trap_wins pc=%h exp=%h", pc_o, e); end
        trap_valid_i = 0;
        exp_q.push_back(32'h100);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL redirect_stalled pc=%h exp=%h", pc_o, e); end
        idle_inputs();
    endtask

    task automatic test_misaligned_halt();
        redirect_valid_i = 1; redirect_target_i = 32'h102;
        exp_q.push_back(32'h100);
        tick();
        redirect_valid_i = 0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e || misaligned_o !== 1'b1) begin
            n_err++; $display("FAIL misaligned pc=%h mis=%b exp %h/1", pc_o, misaligned_o, e);
        end
        exp_q.push_back(32'h104);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e || misaligned_o !== 1'b0) begin
            n_err++; $display("FAIL mis_pulse_end pc=%h mis=%b exp %h/0", pc_o, misaligned_o, e);
        end
        jump(32'h40);
        halt_i = 1;
        exp_q.push_back(32'h44);
        tick();
        halt_i = 0;
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL halt_enter pc=%h req=%b exp %h/0", pc_o, imem_req_o, e);
        end
        exp_q.push_back(32'h44);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e || imem_req_o !== 1'b0) begin
            n_err++; $display("FAIL halt_hold pc=%h req=%b exp %h/0", pc_o, imem_req_o, e);
        end
        jump(32'h200);
        n_cmp++;
        if (imem_req_o !== 1'b1) begin n_err++; $display("FAIL resume_req req=%b exp 1", imem_req_o); end
        halt_i = 1; redirect_valid_i = 1; redirect_target_i = 32'h300;
        exp_q.push_back(32'h300);
        tick();
        idle_inputs();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e || imem_req_o !== 1'b1) begin
            n_err++; $display("FAIL halt_vs_redirect pc=%h req=%b exp %h/1", pc_o, imem_req_o, e);
        end
    endtask

    task automatic test_wrap();
        jump(32'hFFFF_FFFC);
        n_cmp++;
        if (pc_plus_step_o !== 32'h0) begin
            n_err++; $display("FAIL plus_step_wrap got=%h exp=00000000", pc_plus_step_o);
        end
        exp_q.push_back(32'h0);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL pc_wrap pc=%h exp=%h", pc_o, e); end
    endtask

    // Fetch 0x8 and compare the prediction flag and the following PC.
    task automatic fetch_at_8(input bit exp_hit, input string tag);
        jump(32'h8);
        n_cmp++;
        if (pred_taken_o !== exp_hit) begin
            n_err++; $display("FAIL %s pred=%b exp=%b", tag, pred_taken_o, exp_hit);
        end
        exp_q.push_back(exp_hit ? 32'h40 : 32'hC);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (pc_o !== e) begin n_err++; $display("FAIL %s_next pc=%h exp=%h", tag, pc_o, e); end
    endtask

    task automatic test_btb();
        btb_upd_valid_i = 1; btb_upd_taken_i = 1;
        btb_upd_pc_i = 32'h8; btb_upd_target_i = 32'h40;
        jump(32'h1000);
        btb_upd_valid_i = 0;
        fetch_at_8(BTB_ON, "btb_taken");
        n_cmp++;
        if (pred_taken_o !== 1'b0) begin n_err++; $display("FAIL btb_after pred=%b exp=0", pred_taken_o); end
        btb_upd_valid_i = 1; btb_upd_taken_i = 0;
        jump(32'h1000);
        btb_upd_valid_i = 0;
        fetch_at_8(1'b0, "btb_not_taken");
        btb_upd_valid_i = 1; btb_upd_taken_i = 1;
        jump(32'h1000);
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        tick();
        fetch_at_8(1'b0, "btb_after_reset");
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_misaligned_halt();
        test_wrap();
        test_btb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised next-generation program counter for the fetch stage. It adds stall handling, a valid/ready fetch handshake to instruction memory, prioritised redirects (trap, then execute redirect, then sequential), halt/resume and misaligned-target detection. It sits between the execute-stage branch/jump resolution and the instruction memory port. An optional direct-mapped branch target buffer (BTB) can be compiled in.

Parameters:
WIDTH, 32, PC/address width in bits (>= 8)
RESET_VECTOR, 32'h0, PC value loaded on reset
STEP, 4, sequential increment in bytes; must be a power of two
BTB_ENTRIES, 16, BTB depth; power of two, >= 2; used only with PC_BTB_EN

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stall_i  in  1  back-end stall; hold PC, keep request asserted
halt_i  in  1  enter HALT after the current accepted fetch
redirect_valid_i  in  1  execute-stage branch/jump taken
redirect_target_i  in  WIDTH  redirect target (PC+imm or rs1+imm)
trap_valid_i  in  1  exception/interrupt redirect
trap_vector_i  in  WIDTH  trap handler address
imem_req_o  out  1  fetch request valid
imem_addr_o  out  WIDTH  fetch address (= pc_o)
imem_ready_i  in  1  imem accepts the request
pc_o  out  WIDTH  current PC (registered)
pc_plus_step_o  out  WIDTH  pc_o + STEP, combinational, modulo 2^WIDTH
misaligned_o  out  1  one-cycle pulse: a redirect target was rejected
pred_taken_o  out  1  BTB hit used for the next PC (0 without PC_BTB_EN)
btb_upd_valid_i / btb_upd_pc_i / btb_upd_target_i / btb_upd_taken_i  in  1/WIDTH/WIDTH/1  BTB training port (present always; ignored without PC_BTB_EN)

Behaviour:
- FSM states:
  - BOOT: entered on reset; pc_o = RESET_VECTOR; imem_req_o = 0; exits to RUN after 1 cycle.
  - RUN: imem_req_o = 1.
  - HALT: imem_req_o = 0.
- Reset values: pc_o = RESET_VECTOR, imem_req_o = 0, misaligned_o = 0, pred_taken_o = 0, state = BOOT. With PC_BTB_EN, all BTB valid bits are cleared.
- Reset takes priority over everything, including mid-fetch or mid-redirect. A pending handshake is dropped.
- accept = imem_req_o & imem_ready_i & ~stall_i.
- Next-PC priority, evaluated each cycle:
  1. trap_valid_i: pc <= trap_vector_i with bits [1:0] cleared, in any state. Leaves HALT and goes to RUN.
  2. redirect_valid_i with target[1:0] == 0: pc <= target; goes to RUN from HALT.
  3. redirect_valid_i with target[1:0] != 0: pc unchanged; misaligned_o = 1 next cycle; no state change.
  4. accept in RUN: pc <= BTB target if predicted, else pc + STEP.
  5. Otherwise: hold.
- Redirects (1, 2) apply regardless of stall_i or imem_ready_i. They flush the in-flight request, and the new address is presented the next cycle.
- One-cycle latency from any redirect input to pc_o.
- Handshake rules:
  - When imem_req_o = 1 and the request is not accepted, imem_addr_o is stable, unless a redirect occurs.
  - Stall with ready: no advance, request held.
- halt_i in RUN: on the cycle of accept (or immediately if imem_req_o & ~imem_ready_i does not hold), PC advances normally and state goes to HALT.
- halt_i and redirect in the same cycle: the redirect wins and halt is ignored.
- Arithmetic: all adds are unsigned WIDTH-bit with wrap-around; e.g. all-ones - 3 + 4 = 0.

Optional Feature:
PC_BTB_EN:
- Defined: direct-mapped BTB of BTB_ENTRIES entries, each holding {valid, tag, target}.
  - Index = pc[log2(BTB_ENTRIES)+1:2]; tag = the remaining upper bits.
  - Lookup is combinational on pc_o; hit = valid & tag match. A hit on accept selects target, and pred_taken_o = 1 for that cycle.
  - Update on btb_upd_valid_i at the clock edge: taken writes the entry; not-taken clears valid if the tag matches.
  - Update and lookup at the same index in the same cycle: lookup sees the old contents.
- Undefined: no storage; pred_taken_o tied 0; update inputs unused.

Decomposition:
- Package pc_pkg:
  - pc_state_e {BOOT, RUN, HALT}
  - pc_sel_e {SEL_HOLD, SEL_SEQ, SEL_BTB, SEL_REDIR, SEL_TRAP}
  - localparam ALIGN_BITS = 2
  - BTB index/tag width helper functions
- One sub-module, pc_btb (storage, lookup, update), instantiated only under PC_BTB_EN.

Test Plan:
1. Reset -> pc_o = 0x0, imem_req_o = 0 for one cycle. Then with ready = 1 and no stall: PC sequence 0x0, 0x4, 0x8, 0xC.
2. PC = 0x10; stall_i = 1 for 3 cycles with ready = 1 -> pc_o holds 0x10 and imem_req_o stays 1. After the stall releases, the next PC is 0x14.
3. PC = 0x20; redirect to 0x100 while stall_i = 1, with trap_valid_i also asserted to 0x80 in the same cycle -> next PC = 0x80 (trap wins). Repeating without the trap -> 0x100.
4. Redirect to 0x102 -> pc_o unchanged and misaligned_o pulses for exactly 1 cycle. Then halt_i at PC 0x40 with ready = 1 -> PC becomes 0x44, state HALT, imem_req_o = 0. A redirect to 0x200 resumes RUN at 0x200.
5. PC = 0xFFFF_FFFC, accept -> pc_o = 0x0; pc_plus_step_o at 0xFFFF_FFFC reads 0x0.
6. PC_BTB_EN: train pc = 0x8, target = 0x40, taken -> the next fetch of 0x8 goes to 0x40 with pred_taken_o = 1. Retrain as not-taken -> the fetch goes to 0xC. Assert rst mid-run -> BTB empty (0x8 -> 0xC).
